// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with a Start/Busy/Done handshake.
// AND/OR/ADD/SUB/SLT finish one cycle after Start. SLL/SRL shift one bit per
// cycle. MUL is an unsigned shift-add multiply that is built only when
// ALU_MUL_EN is defined; without it, ALUOp 110 behaves like reserved 111.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for Start; operands latched on the accepting edge
// EXEC  | counter != 0: one iteration step; counter == 0: write result
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BNegate,
  input  logic [2:0]       ALUOp,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow,
  output logic             CarryOut
);

  localparam int CW = SHW + 1;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
`ifdef ALU_MUL_EN
  localparam logic [2:0]    OP_MUL  = 3'b110;
  localparam logic [CW-1:0] CNT_MUL = CW'(WIDTH);
`endif

  typedef enum logic {IDLE, EXEC} state_t;

  state_t           state_q, state_d;
  logic             accept, finish;
  logic [CW-1:0]    cnt_q, cnt_load;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             bneg_q;
  logic [WIDTH-1:0] sh_q;
  logic             sh_c;
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] res_d;
  logic             ovf_d, cout_d;

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and handshake outputs
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    Busy    = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        Busy = 1'b1;
        if (cnt_q == '0) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Iteration count loaded on accept; only shifts and MUL need steps
  always_comb begin
    cnt_load = '0;
    case (ALUOp)
      OP_SLL, OP_SRL: cnt_load = {1'b0, B[SHW-1:0]};
`ifdef ALU_MUL_EN
      OP_MUL:         cnt_load = CNT_MUL;
`endif
      default:        cnt_load = '0;
    endcase
  end

  // Operand latches, step counter and the shift work register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q  <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      bneg_q <= 1'b0;
      sh_q   <= '0;
      sh_c   <= 1'b0;
    end else if (accept) begin
      cnt_q  <= cnt_load;
      op_q   <= ALUOp;
      a_q    <= A;
      b_q    <= B;
      bneg_q <= BNegate;
      sh_q   <= A;
      sh_c   <= 1'b0;
    end else if (Busy && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
      if (op_q == OP_SLL) begin
        sh_c <= sh_q[WIDTH-1];
        sh_q <= {sh_q[WIDTH-2:0], 1'b0};
      end else if (op_q == OP_SRL) begin
        sh_c <= sh_q[0];
        sh_q <= {1'b0, sh_q[WIDTH-1:1]};
      end
    end
  end

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH:0]     prod_sum;

  // Partial-product add into the upper half when the multiplier LSB is set
  always_comb begin
    prod_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
    if (prod_q[0]) prod_sum = prod_sum + {1'b0, a_q};
  end

  // Shift-add product register: low half starts as the multiplier
  always_ff @(posedge Clock) begin
    if (Reset)
      prod_q <= '0;
    else if (accept)
      prod_q <= {{WIDTH{1'b0}}, B};
    else if (Busy && cnt_q != '0 && op_q == OP_MUL)
      prod_q <= {prod_sum, prod_q[WIDTH-1:1]};
  end
`endif

  assign bx   = bneg_q ? ~b_q : b_q;
  assign sum  = {1'b0, a_q} + {1'b0, bx} + {{WIDTH{1'b0}}, bneg_q};
  assign diff = a_q - b_q;

  // Final result and flags from the latched operands / iteration state
  always_comb begin
    res_d  = '0;
    ovf_d  = 1'b0;
    cout_d = 1'b0;
    case (op_q)
      OP_AND: res_d = a_q & b_q;
      OP_OR:  res_d = a_q | b_q;
      OP_ADD: begin
        res_d  = sum[WIDTH-1:0];
        cout_d = sum[WIDTH];
        ovf_d  = (a_q[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SLT: res_d = {{(WIDTH-1){1'b0}},
                       diff[WIDTH-1] ^ ((a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                        (diff[WIDTH-1] != a_q[WIDTH-1]))};
      OP_SLL, OP_SRL: begin
        res_d  = sh_q;
        cout_d = sh_c;
      end
`ifdef ALU_MUL_EN
      OP_MUL: begin
        res_d = prod_q[WIDTH-1:0];
        ovf_d = |prod_q[2*WIDTH-1:WIDTH];
      end
`endif
      default: res_d = '0;
    endcase
  end

  // Registered outputs: change only on the finishing edge or reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Done     <= 1'b0;
      Result   <= '0;
      Zero     <= 1'b1;
      Overflow <= 1'b0;
      CarryOut <= 1'b0;
    end else begin
      Done <= finish;
      if (finish) begin
        Result   <= res_d;
        Zero     <= (res_d == '0);
        Overflow <= ovf_d;
        CarryOut <= cout_d;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against an
// arithmetic reference model (honours ALU_MUL_EN the same way as the DUT).
module tb_alu_seq;

  localparam int W = 32;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         Start;
  logic [W-1:0] A, B;
  logic         BNegate;
  logic [2:0]   ALUOp;
  logic         Busy, Done;
  logic [W-1:0] Result;
  logic         Zero, Overflow, CarryOut;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_r;
  logic         exp_ov, exp_co;
  int           exp_lat;

  alu_seq #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .A(A), .B(B),
    .BNegate(BNegate), .ALUOp(ALUOp), .Busy(Busy), .Done(Done),
    .Result(Result), .Zero(Zero), .Overflow(Overflow), .CarryOut(CarryOut)
  );

  always #5 Clock = ~Clock;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: result, flags and Start-to-Done latency in clock edges
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic bn, input logic [2:0] op,
                                output logic [W-1:0] r, output logic ov,
                                output logic co, output int lat);
    longint ua, ub, sa, sb, s;
    int amt;
    logic [63:0] p;
    ua = a; ub = b;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    amt = int'(b[4:0]);
    r = '0; ov = 1'b0; co = 1'b0; lat = 1;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: begin
        if (bn) begin
          r  = a - b;
          co = (ua >= ub);
          s  = sa - sb;
        end else begin
          r  = a + b;
          co = ((ua + ub) >= 64'sh1_0000_0000);
          s  = sa + sb;
        end
        ov = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
      end
      3'd3: r = (sa < sb) ? 32'd1 : 32'd0;
      3'd4: begin
        r   = a << amt;
        co  = (amt == 0) ? 1'b0 : a[32-amt];
        lat = amt + 1;
      end
      3'd5: begin
        r   = a >> amt;
        co  = (amt == 0) ? 1'b0 : a[amt-1];
        lat = amt + 1;
      end
`ifdef ALU_MUL_EN
      3'd6: begin
        p   = {32'd0, a} * {32'd0, b};
        r   = p[31:0];
        ov  = (p[63:32] != 32'd0);
        lat = W + 1;
      end
`endif
      default: r = '0;
    endcase
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bn, input logic [2:0] op);
    A = a; B = b; BNegate = bn; ALUOp = op; Start = 1'b1;
    model(a, b, bn, op, exp_r, exp_ov, exp_co, exp_lat);
  endtask

  // Wait for Done after issue(); scramble inputs and optionally poke Start while busy
  task automatic finish_op(input string tag, input bit pulse);
    int k;
    bit seen;
    @(negedge Clock);
    Start = 1'b0;
    A = $urandom; B = $urandom; BNegate = 1'($urandom % 2); ALUOp = 3'($urandom % 8);
    check_val({tag, ".busy"}, 64'(Busy), 64'd1);
    k = 0; seen = 1'b0;
    while (!seen && k < 100) begin
      @(negedge Clock);
      k++;
      if (Done) seen = 1'b1;
      else if (pulse) begin
        Start = 1'($urandom % 2);
        A = $urandom; B = $urandom;
      end
    end
    Start = 1'b0;
    check_val({tag, ".lat"},  64'(k),        64'(exp_lat));
    check_val({tag, ".res"},  64'(Result),   64'(exp_r));
    check_val({tag, ".zero"}, 64'(Zero),     64'(exp_r == '0));
    check_val({tag, ".ovf"},  64'(Overflow), 64'(exp_ov));
    check_val({tag, ".cout"}, 64'(CarryOut), 64'(exp_co));
  endtask

  task automatic check_idle(input string tag);
    @(negedge Clock);
    check_val({tag, ".done_lo"}, 64'(Done), 64'd0);
    check_val({tag, ".idle"},    64'(Busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcount;
    logic [2:0] op;
    Reset = 1'b1; Start = 1'b0; A = '0; B = '0; BNegate = 1'b0; ALUOp = '0;
    repeat (3) @(negedge Clock);
    check_val("rst.busy", 64'(Busy),     64'd0);
    check_val("rst.done", 64'(Done),     64'd0);
    check_val("rst.res",  64'(Result),   64'd0);
    check_val("rst.zero", 64'(Zero),     64'd1);
    check_val("rst.ovf",  64'(Overflow), 64'd0);
    check_val("rst.cout", 64'(CarryOut), 64'd0);
    Reset = 1'b0;
    @(negedge Clock);

    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 3'd2); finish_op("add_ovf", 1'b0); check_idle("add_ovf");
    issue(32'd5, 32'd5, 1'b1, 3'd2);                 finish_op("sub_zero", 1'b0); check_idle("sub_zero");
    issue(32'h8000_0000, 32'h0000_0001, 1'b0, 3'd3); finish_op("slt_neg", 1'b0); check_idle("slt_neg");
    issue(32'h0000_0001, 32'h8000_0000, 1'b0, 3'd3); finish_op("slt_pos", 1'b0); check_idle("slt_pos");
    issue(32'h0000_0001, 32'h0000_001F, 1'b0, 3'd4); finish_op("sll31", 1'b1); check_idle("sll31");
    issue(32'hDEAD_BEEF, 32'hFFFF_FFE0, 1'b0, 3'd5); finish_op("srl0", 1'b0); check_idle("srl0");
    issue(32'h0001_0000, 32'h0001_0000, 1'b0, 3'd6); finish_op("mul_big", 1'b1); check_idle("mul_big");
    issue(32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 3'd7); finish_op("rsv", 1'b0);
    issue(32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 3'd0); finish_op("and_chain", 1'b0); check_idle("and_chain");

    // Reset in the middle of a 16-step shift aborts it
    issue(32'hFFFF_FFFF, 32'h0000_0010, 1'b0, 3'd5);
    @(negedge Clock); Start = 1'b0;
    repeat (4) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    check_val("abort.busy", 64'(Busy),   64'd0);
    check_val("abort.done", 64'(Done),   64'd0);
    check_val("abort.res",  64'(Result), 64'd0);
    check_val("abort.zero", 64'(Zero),   64'd1);
    Reset = 1'b0;
    dcount = 0;
    repeat (30) begin
      @(negedge Clock);
      if (Done) dcount++;
    end
    check_val("abort.nodone", 64'(dcount), 64'd0);
    issue(32'hFFFF_FFFF, 32'h0000_0010, 1'b0, 3'd5); finish_op("after_rst", 1'b0); check_idle("after_rst");

    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom % 8);
      issue($urandom, $urandom, 1'($urandom % 2), op);
      finish_op("rand", 1'($urandom % 2));
      if ($urandom % 3 != 0) check_idle("rand");
    end
    check_idle("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
